// File: rtl/ttl_latch_reader.sv
// Reader side of a 74LS374-style octal command latch: detects the writer's latch clock, enables the latch outputs for a settle window, and queues the sampled bytes for the reading CPU.
// Optional build macro LATCH_OVERWRITE_EN: a push into a full FIFO replaces the newest entry instead of dropping the incoming byte.
module ttl_latch_reader #(
    parameter int DEPTH       = 4,
    parameter int SETTLE      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       CLK,
    input  logic                       RSTn,
    input  logic                       WR_CLK,
    input  logic [7:0]                 BUS,
    output logic                       LATCH_OCn,
    input  logic                       RD,
    output logic [7:0]                 DOUT,
    output logic                       PENDING,
    output logic                       IRQn,
    output logic                       OVERRUN,
    input  logic                       CLR_OVR,
    output logic [$clog2(DEPTH+1)-1:0] COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   evt_prev_r;
    logic                   wr_evt_s;

    state_t                 state_r, state_s;
    logic [SW-1:0]          cnt_r, cnt_s;
    logic                   evt_q_r, evt_q_s;
    logic                   ocn_r, ocn_s;
    logic                   push_s;
    logic                   evt_ovr_s;

    logic [7:0]             mem_r [DEPTH];
    logic [AW-1:0]          wp_r, rp_r;
    logic [CW-1:0]          count_r, count_s;
    logic [7:0]             dout_r;
    logic                   pending_r, irqn_r, overrun_r;
    logic                   pop_s, full_s, push_ok_s, fifo_ovr_s;

    assign wr_evt_s  = sync_r[SYNC_STAGES-1] & ~evt_prev_r;

    assign LATCH_OCn = ocn_r;
    assign DOUT      = dout_r;
    assign PENDING   = pending_r;
    assign IRQn      = irqn_r;
    assign OVERRUN   = overrun_r;
    assign COUNT     = count_r;

    // WR_CLK synchroniser and rising-edge history
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            sync_r     <= {SYNC_STAGES{1'b0}};
            evt_prev_r <= 1'b0;
        end else begin
            sync_r     <= {sync_r[SYNC_STAGES-2:0], WR_CLK};
            evt_prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Capture FSM next-state; a second event arriving while one is queued is lost
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        evt_q_s   = evt_q_r;
        ocn_s     = ocn_r;
        push_s    = 1'b0;
        if (wr_evt_s && evt_q_r) begin
            evt_ovr_s = 1'b1;
        end else begin
            evt_ovr_s = 1'b0;
        end
        case (state_r)
            ST_IDLE: begin
                if (wr_evt_s || evt_q_r) begin
                    state_s = ST_DRIVE;
                    ocn_s   = 1'b0;
                    cnt_s   = SW'(SETTLE - 1);
                    evt_q_s = 1'b0;
                end else begin
                    ocn_s   = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (wr_evt_s) begin
                    evt_q_s = 1'b1;
                end else begin
                    evt_q_s = evt_q_r;
                end
                if (cnt_r == {SW{1'b0}}) begin
                    state_s = ST_SAMPLE;
                end else begin
                    cnt_s   = cnt_r - SW'(1);
                end
            end
            ST_SAMPLE: begin
                if (wr_evt_s) begin
                    evt_q_s = 1'b1;
                end else begin
                    evt_q_s = evt_q_r;
                end
                push_s  = 1'b1;
                ocn_s   = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                ocn_s   = 1'b1;
                evt_q_s = 1'b0;
            end
        endcase
    end

    // Capture FSM registers
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_r <= ST_IDLE;
            cnt_r   <= {SW{1'b0}};
            evt_q_r <= 1'b0;
            ocn_r   <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            evt_q_r <= evt_q_s;
            ocn_r   <= ocn_s;
        end
    end

    // FIFO control: a same-cycle pop frees the slot, so a full FIFO still accepts the push
    always_comb begin
        pop_s      = RD && (count_r != {CW{1'b0}});
        full_s     = (count_r == CW'(DEPTH));
        push_ok_s  = push_s && (!full_s || pop_s);
        fifo_ovr_s = push_s && full_s && !pop_s;
        if (push_ok_s && !pop_s) begin
            count_s = count_r + CW'(1);
        end else if (pop_s && !push_ok_s) begin
            count_s = count_r - CW'(1);
        end else begin
            count_s = count_r;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate every read
    always_ff @(posedge CLK) begin
        if (RSTn && push_ok_s) begin
            mem_r[wp_r] <= BUS;
`ifdef LATCH_OVERWRITE_EN
        end else if (RSTn && fifo_ovr_s) begin
            mem_r[wp_r - AW'(1)] <= BUS;
`endif
        end
    end

    // FIFO pointers, read data and CPU-facing flags
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            wp_r      <= {AW{1'b0}};
            rp_r      <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            dout_r    <= 8'h00;
            pending_r <= 1'b0;
            irqn_r    <= 1'b1;
            overrun_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wp_r <= wp_r + AW'(1);
            end
            if (pop_s) begin
                rp_r   <= rp_r + AW'(1);
                dout_r <= mem_r[rp_r];
            end
            count_r   <= count_s;
            pending_r <= (count_s != {CW{1'b0}});
            irqn_r    <= (count_s == {CW{1'b0}});
            if (evt_ovr_s || fifo_ovr_s) begin
                overrun_r <= 1'b1;
            end else if (CLR_OVR) begin
                overrun_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ttl_latch_reader.sv
// Self-checking bench for ttl_latch_reader: directed scenarios plus randomized traffic against a byte-queue reference model.
module tb_ttl_latch_reader;

    localparam int DEPTH       = 4;
    localparam int SETTLE      = 2;
    localparam int SYNC_STAGES = 2;
    localparam int CW          = $clog2(DEPTH + 1);

    logic          CLK = 1'b0;
    logic          RSTn, WR_CLK, RD, CLR_OVR;
    logic [7:0]    BUS;
    logic          LATCH_OCn, PENDING, IRQn, OVERRUN;
    logic [7:0]    DOUT;
    logic [CW-1:0] COUNT;

    int errors = 0;
    int checks = 0;

    logic [7:0] q[$];
    logic [7:0] m_dout;
    logic       m_ovr;

    ttl_latch_reader #(.DEPTH(DEPTH), .SETTLE(SETTLE), .SYNC_STAGES(SYNC_STAGES)) dut (
        .CLK(CLK), .RSTn(RSTn), .WR_CLK(WR_CLK), .BUS(BUS), .LATCH_OCn(LATCH_OCn),
        .RD(RD), .DOUT(DOUT), .PENDING(PENDING), .IRQn(IRQn), .OVERRUN(OVERRUN),
        .CLR_OVR(CLR_OVR), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        q.delete();
        m_dout = 8'h00;
        m_ovr  = 1'b0;
    endtask

    // reference: optional same-sample pop, then a push that either fits or overruns
    task automatic model_write(input logic [7:0] b, input bit rd);
        if (rd && q.size() > 0) m_dout = q.pop_front();
        if (q.size() < DEPTH) begin
            q.push_back(b);
        end else begin
            m_ovr = 1'b1;
`ifdef LATCH_OVERWRITE_EN
            q[q.size()-1] = b;
`endif
        end
    endtask

    // one writer strobe; returns the number of CLK cycles LATCH_OCn was seen low
    task automatic do_write(input logic [7:0] b, input bit rd, output int lows);
        bit done;
        lows = 0;
        done = 1'b0;
        @(negedge CLK);
        BUS    = b;
        WR_CLK = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge CLK);
            RD = 1'b0;
            if (i == 3) WR_CLK = 1'b0;
            if (!LATCH_OCn) begin
                lows++;
                if (rd && lows == SETTLE + 1) RD = 1'b1;
            end else if (lows > 0 && i >= 3) begin
                done = 1'b1;
            end
        end
        WR_CLK = 1'b0;
        RD     = 1'b0;
        repeat (2) @(negedge CLK);
        model_write(b, rd);
    endtask

    task automatic do_read();
        @(negedge CLK);
        RD = 1'b1;
        @(negedge CLK);
        RD = 1'b0;
        if (q.size() > 0) m_dout = q.pop_front();
    endtask

    task automatic do_clr();
        @(negedge CLK);
        CLR_OVR = 1'b1;
        @(negedge CLK);
        CLR_OVR = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic test_reset();
        RSTn = 1'b0; WR_CLK = 1'b0; RD = 1'b0; CLR_OVR = 1'b0; BUS = 8'h00;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (LATCH_OCn !== 1'b1 || DOUT !== 8'h00 || COUNT !== CW'(0) || IRQn !== 1'b1 ||
                OVERRUN !== 1'b0 || PENDING !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: ocn=%b dout=%h count=%0d irqn=%b ovr=%b pend=%b, want 1 00 0 1 0 0",
                         i, LATCH_OCn, DOUT, COUNT, IRQn, OVERRUN, PENDING);
            end
            WR_CLK = ~WR_CLK;
        end
        WR_CLK = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (4) @(negedge CLK);
        checks++;
        if (COUNT !== CW'(0) || LATCH_OCn !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: count=%0d ocn=%b, want 0 1", COUNT, LATCH_OCn);
        end
    endtask

    task automatic test_single();
        int lows;
        do_write(8'hA5, 1'b0, lows);
        checks++;
        if (lows != SETTLE + 1) begin
            errors++;
            $display("FAIL single_ocn_width: got %0d cycles want %0d", lows, SETTLE + 1);
        end
        checks++;
        if (COUNT !== CW'(1) || PENDING !== 1'b1 || IRQn !== 1'b0) begin
            errors++;
            $display("FAIL single_flags: count=%0d pend=%b irqn=%b, want 1 1 0", COUNT, PENDING, IRQn);
        end
        do_read();
        checks++;
        if (DOUT !== 8'hA5 || COUNT !== CW'(0) || IRQn !== 1'b1) begin
            errors++;
            $display("FAIL single_read: dout=%h count=%0d irqn=%b, want a5 0 1", DOUT, COUNT, IRQn);
        end
    endtask

    task automatic test_overrun();
        int lows;
        logic [7:0] exp [4];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
`ifdef LATCH_OVERWRITE_EN
        exp[3] = 8'h55;
`else
        exp[3] = 8'h44;
`endif
        for (int i = 1; i <= 5; i++) do_write(8'(i * 8'h11), 1'b0, lows);
        checks++;
        if (COUNT !== CW'(4) || OVERRUN !== 1'b1) begin
            errors++;
            $display("FAIL ovr_full: count=%0d ovr=%b, want 4 1", COUNT, OVERRUN);
        end
        for (int i = 0; i < 4; i++) begin
            do_read();
            checks++;
            if (DOUT !== exp[i]) begin
                errors++;
                $display("FAIL ovr_read[%0d]: dout=%h want %h", i, DOUT, exp[i]);
            end
        end
        do_clr();
        checks++;
        if (OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear: ovr=%b want 0", OVERRUN);
        end
    endtask

    task automatic test_full_rd_sample();
        int lows;
        for (int i = 0; i < 4; i++) do_write(8'($urandom_range(0, 255)), 1'b0, lows);
        do_write(8'h66, 1'b1, lows);
        checks++;
        if (COUNT !== CW'(4) || OVERRUN !== 1'b0 || DOUT !== m_dout) begin
            errors++;
            $display("FAIL full_rd_sample: count=%0d ovr=%b dout=%h, want 4 0 %h", COUNT, OVERRUN, DOUT, m_dout);
        end
        for (int i = 0; i < 4; i++) begin
            do_read();
            checks++;
            if (DOUT !== m_dout) begin
                errors++;
                $display("FAIL full_rd_drain[%0d]: dout=%h want %h", i, DOUT, m_dout);
            end
        end
        checks++;
        if (DOUT !== 8'h66) begin
            errors++;
            $display("FAIL full_rd_last: dout=%h want 66", DOUT);
        end
    endtask

    task automatic test_rd_empty_and_burst();
        int lows;
        logic [7:0] b;
        do_write(8'h44, 1'b0, lows);
        do_read();
        do_read();
        checks++;
        if (DOUT !== 8'h44 || COUNT !== CW'(0) || OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL rd_empty: dout=%h count=%0d ovr=%b, want 44 0 0", DOUT, COUNT, OVERRUN);
        end
        // three writer edges two cycles apart: one captured, one queued, one lost
        b = 8'($urandom_range(0, 255));
        @(negedge CLK);
        BUS = b;
        for (int k = 0; k < 3; k++) begin
            WR_CLK = 1'b1;
            @(negedge CLK);
            WR_CLK = 1'b0;
            @(negedge CLK);
        end
        repeat (12) @(negedge CLK);
        q.push_back(b);
        q.push_back(b);
        m_ovr = 1'b1;
        checks++;
        if (COUNT !== CW'(2) || OVERRUN !== 1'b1) begin
            errors++;
            $display("FAIL burst: count=%0d ovr=%b, want 2 1", COUNT, OVERRUN);
        end
        for (int i = 0; i < 2; i++) begin
            do_read();
            checks++;
            if (DOUT !== b) begin
                errors++;
                $display("FAIL burst_read[%0d]: dout=%h want %h", i, DOUT, b);
            end
        end
        do_clr();
    endtask

    task automatic test_reset_mid();
        int lows;
        bit seen;
        logic [7:0] b;
        seen = 1'b0;
        @(negedge CLK);
        BUS    = 8'($urandom_range(0, 255));
        WR_CLK = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            if (!LATCH_OCn) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid_drive: LATCH_OCn never went low within 10 cycles");
        end
        WR_CLK = 1'b0;
        RSTn   = 1'b0;
        @(negedge CLK);
        model_reset();
        checks++;
        if (LATCH_OCn !== 1'b1 || COUNT !== CW'(0)) begin
            errors++;
            $display("FAIL reset_mid: ocn=%b count=%0d, want 1 0", LATCH_OCn, COUNT);
        end
        RSTn = 1'b1;
        repeat (8) @(negedge CLK);
        checks++;
        if (LATCH_OCn !== 1'b1 || COUNT !== CW'(0)) begin
            errors++;
            $display("FAIL reset_mid_nopush: ocn=%b count=%0d, want 1 0", LATCH_OCn, COUNT);
        end
        b = 8'($urandom_range(0, 255));
        do_write(b, 1'b0, lows);
        do_read();
        checks++;
        if (DOUT !== b || COUNT !== CW'(0)) begin
            errors++;
            $display("FAIL reset_mid_after: dout=%h count=%0d, want %h 0", DOUT, COUNT, b);
        end
    endtask

    task automatic test_random();
        int lows;
        int op;
        for (int n = 0; n < 40; n++) begin
            op   = $urandom_range(0, 9);
            lows = SETTLE + 1;
            if (op < 5) do_write(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), lows);
            else if (op < 9) do_read();
            else do_clr();
            checks++;
            if (lows != SETTLE + 1 || COUNT !== CW'(q.size()) || PENDING !== (q.size() != 0) ||
                IRQn !== (q.size() == 0) || OVERRUN !== m_ovr || DOUT !== m_dout) begin
                errors++;
                $display("FAIL random[%0d] op=%0d: lows=%0d count=%0d pend=%b irqn=%b ovr=%b dout=%h, want %0d %0d %b %b %b %h",
                         n, op, lows, COUNT, PENDING, IRQn, OVERRUN, DOUT,
                         SETTLE + 1, q.size(), q.size() != 0, q.size() == 0, m_ovr, m_dout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_full_rd_sample();
        test_rd_empty_and_burst();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
